// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit: computes the result on accept, holds busy for a
// fixed latency, then commits the staged value into the architectural HI/LO.
module ex_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        md_valid,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        hilo_sel,
  output logic        busy,
  output logic [31:0] md_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;
  logic          keep_q, keep_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          accept;
  logic [63:0]   prod_s, prod_u;
  logic          div_signed;
  logic [31:0]   dvd, dvs, dvs_nz, quo, rem, div_lo, div_hi;

  assign accept = md_valid & ~req & ~busy_q & ~reset;

  // Both operand widths are extended to 64 bits so the low 64 bits are the exact product.
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'b0, A} * {32'b0, B};

  // Signed divide runs on magnitudes; the quotient takes the XOR of the signs and
  // the remainder takes the dividend's sign. Zero divisor is replaced to keep the
  // datapath defined; its result is discarded via keep.
  assign div_signed = (md_op == OP_DIV);
  assign dvd    = (div_signed && A[31]) ? -A : A;
  assign dvs    = (div_signed && B[31]) ? -B : B;
  assign dvs_nz = (dvs == 32'd0) ? 32'd1 : dvs;
  assign quo    = dvd / dvs_nz;
  assign rem    = dvd % dvs_nz;
  assign div_lo = (div_signed && (A[31] ^ B[31])) ? -quo : quo;
  assign div_hi = (div_signed && A[31]) ? -rem : rem;

  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    keep_d   = keep_q;
    cnt_d    = cnt_q;

    if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1) && !keep_q) begin
        hi_d = hi_tmp_q;
        lo_d = lo_tmp_q;
      end
    end

    if (accept) begin
      case (md_op)
        OP_MULT: begin
          hi_tmp_d = prod_s[63:32];
          lo_tmp_d = prod_s[31:0];
          keep_d   = 1'b0;
          cnt_d    = CW'(MULT_CYCLES);
        end
        OP_MULTU: begin
          hi_tmp_d = prod_u[63:32];
          lo_tmp_d = prod_u[31:0];
          keep_d   = 1'b0;
          cnt_d    = CW'(MULT_CYCLES);
        end
        OP_DIV, OP_DIVU: begin
          hi_tmp_d = div_hi;
          lo_tmp_d = div_lo;
          keep_d   = (B == 32'd0);
          cnt_d    = CW'(DIV_CYCLES);
        end
        OP_MTHI: hi_d = A;
        OP_MTLO: lo_d = A;
        default: ;
      endcase
    end

    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q     <= '0;
      lo_q     <= '0;
      hi_tmp_q <= '0;
      lo_tmp_q <= '0;
      keep_q   <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
      keep_q   <= keep_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy   = busy_q;
  assign md_out = hilo_sel ? hi_q : lo_q;

endmodule

// File: doc/ex_mdu.md
# ex_mdu

Multiply/divide unit for the EX stage of the five-stage MIPS pipeline. Executes `mult`, `multu`, `div`, `divu`, `mthi` and `mtlo` against private HI/LO registers, and holds `busy` for a fixed latency so the decode-stage stall logic can block dependent HI/LO instructions. Its read port supplies `mfhi`/`mflo` results to the EX result mux, and from there to MEM. It honours the exception/interrupt request so that a flushed EX instruction never modifies HI/LO.

## Interface
Parameters:
- `MULT_CYCLES`, default 5, busy duration of `mult`/`multu` (≥1).
- `DIV_CYCLES`, default 10, busy duration of `div`/`divu` (≥1).

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  1  exception/interrupt request; the EX instruction is being flushed this cycle.
- `md_valid`  in  1  EX instruction is an MDU operation.
- `md_op`  in  3  operation code:
  - 000 = MULT, 001 = MULTU, 010 = DIV, 011 = DIVU, 100 = MTHI, 101 = MTLO.
  - 110 and 111 are ignored.
- `A`  in  32  forwarded rs value.
- `B`  in  32  forwarded rt value.
- `hilo_sel`  in  1  read select: 1 = HI, 0 = LO.
- `busy`  out  1  registered; high while a multiply or divide is in flight.
- `md_out`  out  32  combinational read: HI if `hilo_sel` is 1, otherwise LO.

## Operation
- Acceptance rule: `accept = md_valid & ~req & ~busy & ~reset`. Nothing in this unit changes on an unaccepted request.
- MULT: 64-bit signed product of A and B; HI = bits [63:32], LO = bits [31:0].
- MULTU: the same, with both operands unsigned.
- DIV: signed division with the quotient truncated toward zero.
  - LO = quotient; HI = remainder, which takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- DIVU: unsigned division; LO = quotient, HI = remainder.
- Divide by zero (DIV or DIVU with B = 0):
  - busy still runs the full `DIV_CYCLES`.
  - HI and LO are left unchanged at commit.
- Compute path:
  - On accept, the result (or a "keep" flag for divide by zero) is latched into internal `hi_tmp`/`lo_tmp`.
  - A down-counter is loaded with N (`MULT_CYCLES` or `DIV_CYCLES`).
- Counter behaviour:
  - While the counter is nonzero it decrements every cycle and `busy` is 1.
  - On the transition 1→0, `hi_tmp`/`lo_tmp` are committed to HI/LO.
- MTHI/MTLO: on accept, HI or LO is written with A at the clock edge; `busy` is not affected.
- `md_valid` while `busy` is 1 is dropped. The pipeline stalls on `busy`, so this case is defensive only.
- `req` does not stop an in-flight operation. The instruction that started it has already left EX and is treated as committed; its result is still written to HI/LO.
- `md_out` reads the architectural HI/LO only. While `busy` is 1 it returns the old values.

## Timing
- Reset values: HI = 0, LO = 0, `busy` = 0, counter = 0, tmp registers = 0. `md_out` is therefore 0.
- Reset in any cycle, including mid-operation:
  - aborts the operation;
  - `busy` is 0 in the following cycle;
  - the pending result is never committed.
- Multiply/divide accepted in cycle t:
  - `busy` = 1 in cycles t+1 through t+N.
  - HI/LO update at the end of cycle t+N.
  - In cycle t+N+1, `busy` = 0 and `md_out` shows the new values.
- Back-to-back operations: a new operation is accepted in cycle t+N+1, the first cycle with `busy` low. The stall logic must treat `md_valid & md_op ∈ {0..3}` in cycle t as busy (start-or-busy).
- MTHI/MTLO accepted in cycle t: the new value is visible on `md_out` in cycle t+1; zero busy cycles.
- `req` and `md_valid` in the same cycle: the request is not accepted; the state is identical to an idle cycle.
- Counter width is ceil(log2(max(MULT_CYCLES, DIV_CYCLES) + 1)) bits; it never wraps, and an idle counter stays at 0.

## Test plan
- Reset, then MULT A = 0xFFFFFFFF, B = 2 → `busy` high for exactly 5 cycles, then HI = 0xFFFFFFFF, LO = 0xFFFFFFFE. MULTU on the same operands → HI = 0x00000001, LO = 0xFFFFFFFE.
- DIV A = 0xFFFFFFF9 (-7), B = 2 → `busy` high for 10 cycles, then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU A = 7, B = 2 → LO = 3, HI = 1. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 → each visible the next cycle with no busy cycles. Then DIV with B = 0 → 10 busy cycles, HI/LO still 0x12345678 / 0x9ABCDEF0.
- MULT with `req` = 1 → `busy` stays 0, HI/LO unchanged. MTLO 0x55 with `req` = 1 → LO unchanged.
- During a DIV, assert `req` in busy cycle 2 → the result still commits after cycle 10. Assert `reset` in busy cycle 3 of another DIV → `busy` = 0 and HI = LO = 0 the next cycle, and no later commit occurs.
- MULT, then a second MULT presented in the first cycle with `busy` low (t+6) → accepted; `md_out` shows the first result in t+6 and the second in t+12. `md_valid` while busy → ignored.
